ctrl_pipe: RTL and testbench
============================

Name: ctrl_pipe

Overview:
- Consumer end of the main decoder's control outputs.
- Carries the decoded control bundle and destination register from ID through the EX, MEM and WB pipeline stages.
- Detects load-use hazards and stalls the front end, inserting a bubble into EX.
- Squashes wrong-path instructions on a taken branch or jump.
- Optionally generates EX-stage operand forwarding selects.

Parameters:
- REGW, 5, register index width.
- CTRLW, 12, packed control bundle width (layout fixed in package).

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_ctrl  in  CTRLW  bundle from the decoder: {Branch, ALUOp[1:0], UIOp[1:0], jal_signal, JalrSel, MemWrite, MemRead, RegWrite, MemtoReg, ALUSrc}, MSB..LSB.
- id_rs1  in  REGW  source register 1 of ID instruction.
- id_rs2  in  REGW  source register 2 of ID instruction.
- id_rd  in  REGW  destination of ID instruction.
- ex_take  in  1  branch unit in EX resolved taken (branch/jal/jalr).
- ex_ctrl, mem_ctrl, wb_ctrl  out  CTRLW  registered bundle per stage.
- ex_rd, mem_rd, wb_rd  out  REGW  registered destination per stage.
- ex_rs1, ex_rs2  out  REGW  registered sources in EX.
- ex_valid, mem_valid, wb_valid  out  1  stage holds a real instruction.
- stall_if  out  1  hold PC and IF/ID register this cycle.
- flush_ifid  out  1  squash IF/ID register this cycle.
- fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 01 WB result, 10 MEM ALU result.

Behaviour:
- Reset (async, rst_n=0): all *_ctrl=0, *_rd=0, ex_rs1/ex_rs2=0, all *_valid=0. Combinational outputs follow from these zeroed registers.
- Release takes effect on the next rising clk. Reset mid-stream drops every in-flight instruction; no partial writeback.
- Stage advance every cycle: EX <= ID, MEM <= EX, WB <= MEM. Latency ID->WB is 3 cycles. MEM and WB never stall.
- A bubble means valid=0 and ctrl=0. A bubble must never assert RegWrite, MemRead or MemWrite downstream.
- id_valid=0 loads a bubble into EX.
- load_use (comb) = ex_valid & ex MemRead & ex_rd!=0 & id_valid & (ex_rd==id_rs1 | ex_rd==id_rs2).
  - Comparison is conservative: rs2 is compared even for instructions that do not read it.
- flush (comb) = ex_take & ex_valid.
- Priority is flush > load_use > normal.
  - flush: EX <= bubble, flush_ifid=1, stall_if=0. The instruction in EX proceeds to MEM normally (jal/jalr link write preserved).
  - load_use, no flush: EX <= bubble, stall_if=1, flush_ifid=0. ID is re-presented the next cycle, and the stall lasts exactly 1 cycle.
  - normal: stall_if=0, flush_ifid=0.
- x0 rule: rd==0 never produces a hazard or a forward.
- Simultaneous MEM and WB match on the same source: MEM (newer) wins.

Optional Feature:
- Macro CTRL_PIPE_FWD_EN.
- Defined:
  - fwd_a = 10 if mem_valid & mem RegWrite & mem_rd!=0 & mem_rd==ex_rs1.
  - Else fwd_a = 01 if wb_valid & wb RegWrite & wb_rd!=0 & wb_rd==ex_rs1.
  - Else fwd_a = 00.
  - fwd_b is the same against ex_rs2.
  - Only load-use stalls.
- Undefined:
  - fwd_a = fwd_b = 00 always.
  - The stall condition extends to any RAW on id_rs1/id_rs2 with a valid RegWrite, rd!=0 instruction in EX or MEM, not only loads.
  - Stall repeats each cycle until the producer reaches WB.
  - The register file must write-before-read.

Decomposition:
- Package ctrl_pipe_pkg:
  - ctrl_bundle_t packed struct (bit layout above).
  - CTRL_BUBBLE constant (all zero).
  - fwd_sel_t enum {FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10}.
  - Opcode constants shared with the decoder.
- Sub-module hazard_unit: combinational load_use/stall/flush and fwd select logic. ctrl_pipe holds only the stage registers.

Test Plan:
- Reset: rst_n=0 asserted mid-stream with RegWrite bundles in flight -> all *_valid=0 and *_ctrl=0 immediately; first valid WB appears 3 cycles after the first valid ID post-release.
- Load-use: lw x5 in EX, ID add x6,x5,x1 -> stall_if=1 for 1 cycle, ex_valid=0 next cycle; add reaches EX one cycle later; with FWD_EN, fwd_a=01 then.
- x0 immunity: lw x0 in EX, ID reads x0 -> stall_if=0, fwd_a=fwd_b=00.
- Taken branch: beq in EX with ex_take=1, ID holds add -> flush_ifid=1, EX bubble, beq reaches MEM; jal case: wb RegWrite=1 with wb_rd=1, two cycles after flush.
- Flush vs load-use: ex_take=1 and load_use same cycle -> flush_ifid=1, stall_if=0.
- Forwarding priority (FWD_EN): add x3 in MEM, addi x3 in WB, EX reads x3 as rs1 and rs2 -> fwd_a=fwd_b=10. Without macro -> ID-stage stall asserted until producers clear and fwd=00.

Source files
------------

// File: rtl/ctrl_pipe_pkg.sv
// ctrl_pipe_pkg: types and constants shared by the decoder and the
// ID->EX->MEM->WB control pipeline.
//   ctrl_bundle_t : packed control bundle, MSB..LSB
//                   {branch, alu_op[1:0], ui_op[1:0], jal_signal, jalr_sel,
//                    mem_write, mem_read, reg_write, memto_reg, alu_src}
//   CTRL_BUBBLE   : all-zero bundle (no side effects downstream)
//   fwd_sel_t     : EX operand source select
//   OP_*          : RV32I major opcodes as decoded upstream
package ctrl_pipe_pkg;

  localparam int STAGES = 3;  // EX, MEM, WB

  typedef struct packed {
    logic       branch;
    logic [1:0] alu_op;
    logic [1:0] ui_op;
    logic       jal_signal;
    logic       jalr_sel;
    logic       mem_write;
    logic       mem_read;
    logic       reg_write;
    logic       memto_reg;
    logic       alu_src;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_BUBBLE = '0;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

endpackage

// File: rtl/ctrl_pipe_hazard_unit.sv
// hazard_unit: combinational hazard detection for ctrl_pipe.
//   Inputs : ID sources/valid, branch outcome, EX/MEM/WB valid, write
//            enables and destinations, EX sources.
//   Outputs: stall_if (hold PC + IF/ID), flush_ifid (squash IF/ID),
//            bubble_ex (load a bubble into EX), fwd_a/fwd_b (EX operand src).
// Build option CTRL_PIPE_FWD_EN: when defined, EX forwarding is generated and
// only load-use stalls; otherwise every RAW against EX or MEM stalls until the
// producer reaches WB (register file writes before it reads).
module hazard_unit
  import ctrl_pipe_pkg::*;
#(
  parameter int REGW = 5
) (
  input  logic            id_valid,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic            ex_take,
  input  logic            ex_valid,
  input  logic            ex_mem_read,
  input  logic            ex_reg_write,
  input  logic [REGW-1:0] ex_rd,
  input  logic [REGW-1:0] ex_rs1,
  input  logic [REGW-1:0] ex_rs2,
  input  logic            mem_valid,
  input  logic            mem_reg_write,
  input  logic [REGW-1:0] mem_rd,
  input  logic            wb_valid,
  input  logic            wb_reg_write,
  input  logic [REGW-1:0] wb_rd,
  output logic            stall_if,
  output logic            flush_ifid,
  output logic            bubble_ex,
  output fwd_sel_t        fwd_a,
  output fwd_sel_t        fwd_b
);

  // Producer/consumer match; x0 is never a dependency.
  function automatic logic hit(input logic vld, input logic wr,
                               input logic [REGW-1:0] rd,
                               input logic [REGW-1:0] rs);
    return vld & wr & (rd != '0) & (rd == rs);
  endfunction

  logic load_use, flush, stall_cond;

  // rs2 is compared even for formats without rs2: a spare stall is harmless.
  assign load_use = ex_valid & ex_mem_read & (ex_rd != '0) & id_valid &
                    ((ex_rd == id_rs1) | (ex_rd == id_rs2));
  assign flush    = ex_take & ex_valid;

`ifdef CTRL_PIPE_FWD_EN
  assign stall_cond = load_use;

  // MEM holds the newer value, so it is checked first.
  always_comb begin
    fwd_a = FWD_RF;
    if (hit(mem_valid, mem_reg_write, mem_rd, ex_rs1))    fwd_a = FWD_MEM;
    else if (hit(wb_valid, wb_reg_write, wb_rd, ex_rs1))  fwd_a = FWD_WB;
  end

  always_comb begin
    fwd_b = FWD_RF;
    if (hit(mem_valid, mem_reg_write, mem_rd, ex_rs2))    fwd_b = FWD_MEM;
    else if (hit(wb_valid, wb_reg_write, wb_rd, ex_rs2))  fwd_b = FWD_WB;
  end

  logic unused_nofwd;
  assign unused_nofwd = ex_reg_write;
`else
  logic raw_ex, raw_mem;
  assign raw_ex  = id_valid & (hit(ex_valid, ex_reg_write, ex_rd, id_rs1) |
                               hit(ex_valid, ex_reg_write, ex_rd, id_rs2));
  assign raw_mem = id_valid & (hit(mem_valid, mem_reg_write, mem_rd, id_rs1) |
                               hit(mem_valid, mem_reg_write, mem_rd, id_rs2));
  // load_use kept explicitly so a load without reg_write still interlocks.
  assign stall_cond = load_use | raw_ex | raw_mem;

  assign fwd_a = FWD_RF;
  assign fwd_b = FWD_RF;

  logic unused_fwd;
  assign unused_fwd = ^{ex_rs1, ex_rs2, wb_valid, wb_reg_write, wb_rd};
`endif

  // A flushed ID instruction is wrong-path, so it need not be held.
  assign flush_ifid = flush;
  assign stall_if   = stall_cond & ~flush;
  assign bubble_ex  = flush | stall_cond;

endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: carries the decoded control bundle and register indices from
// ID through EX, MEM and WB, inserting bubbles on load-use / RAW stalls and
// taken-branch flushes.
//   clk, rst_n         : clock, async active-low reset
//   id_*               : instruction currently in ID
//   ex_take            : branch unit in EX resolved taken
//   {ex,mem,wb}_ctrl/rd/valid : registered per-stage state
//   ex_rs1/ex_rs2      : registered EX sources
//   stall_if/flush_ifid: front-end control
//   fwd_a/fwd_b        : EX operand select (00 RF, 01 WB, 10 MEM)
// Build option CTRL_PIPE_FWD_EN enables forwarding (see hazard_unit).
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int REGW  = 5,
  parameter int CTRLW = 12  // must equal $bits(ctrl_bundle_t)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [CTRLW-1:0] id_ctrl,
  input  logic [REGW-1:0]  id_rs1,
  input  logic [REGW-1:0]  id_rs2,
  input  logic [REGW-1:0]  id_rd,
  input  logic             ex_take,
  output logic [CTRLW-1:0] ex_ctrl,
  output logic [CTRLW-1:0] mem_ctrl,
  output logic [CTRLW-1:0] wb_ctrl,
  output logic [REGW-1:0]  ex_rd,
  output logic [REGW-1:0]  mem_rd,
  output logic [REGW-1:0]  wb_rd,
  output logic [REGW-1:0]  ex_rs1,
  output logic [REGW-1:0]  ex_rs2,
  output logic             ex_valid,
  output logic             mem_valid,
  output logic             wb_valid,
  output logic             stall_if,
  output logic             flush_ifid,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b
);

  ctrl_bundle_t    id_c, ex_q, mem_q, wb_q;
  logic [REGW-1:0] ex_rd_q, mem_rd_q, wb_rd_q, ex_rs1_q, ex_rs2_q;
  logic [STAGES:1] vld_pipe;  // [1]=EX, [2]=MEM, [3]=WB
  logic            bubble_ex, ex_load;
  fwd_sel_t        fwd_a_s, fwd_b_s;

  assign id_c    = ctrl_bundle_t'(id_ctrl);
  assign ex_load = id_valid & ~bubble_ex;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      ex_q     <= CTRL_BUBBLE;
      mem_q    <= CTRL_BUBBLE;
      wb_q     <= CTRL_BUBBLE;
      ex_rd_q  <= '0;
      mem_rd_q <= '0;
      wb_rd_q  <= '0;
      ex_rs1_q <= '0;
      ex_rs2_q <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], ex_load};
      // Bubbles are fully zeroed so stale indices cannot match downstream.
      if (ex_load) begin
        ex_q     <= id_c;
        ex_rd_q  <= id_rd;
        ex_rs1_q <= id_rs1;
        ex_rs2_q <= id_rs2;
      end else begin
        ex_q     <= CTRL_BUBBLE;
        ex_rd_q  <= '0;
        ex_rs1_q <= '0;
        ex_rs2_q <= '0;
      end
      mem_q    <= ex_q;
      mem_rd_q <= ex_rd_q;
      wb_q     <= mem_q;
      wb_rd_q  <= mem_rd_q;
    end
  end

  hazard_unit #(.REGW(REGW)) u_hz (
    .id_valid      (id_valid),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .ex_take       (ex_take),
    .ex_valid      (vld_pipe[1]),
    .ex_mem_read   (ex_q.mem_read),
    .ex_reg_write  (ex_q.reg_write),
    .ex_rd         (ex_rd_q),
    .ex_rs1        (ex_rs1_q),
    .ex_rs2        (ex_rs2_q),
    .mem_valid     (vld_pipe[2]),
    .mem_reg_write (mem_q.reg_write),
    .mem_rd        (mem_rd_q),
    .wb_valid      (vld_pipe[3]),
    .wb_reg_write  (wb_q.reg_write),
    .wb_rd         (wb_rd_q),
    .stall_if      (stall_if),
    .flush_ifid    (flush_ifid),
    .bubble_ex     (bubble_ex),
    .fwd_a         (fwd_a_s),
    .fwd_b         (fwd_b_s)
  );

  assign ex_ctrl   = ex_q;
  assign mem_ctrl  = mem_q;
  assign wb_ctrl   = wb_q;
  assign ex_rd     = ex_rd_q;
  assign mem_rd    = mem_rd_q;
  assign wb_rd     = wb_rd_q;
  assign ex_rs1    = ex_rs1_q;
  assign ex_rs2    = ex_rs2_q;
  assign ex_valid  = vld_pipe[1];
  assign mem_valid = vld_pipe[2];
  assign wb_valid  = vld_pipe[3];
  assign fwd_a     = fwd_a_s;
  assign fwd_b     = fwd_b_s;

endmodule

// File: tb/tb_ctrl_pipe.sv
module tb_ctrl_pipe;

  localparam int REGW  = 5;
  localparam int CTRLW = 12;

  // Bundles: {br, aluop[1:0], uiop[1:0], jal, jalr, mw, mr, rw, mt, as}
  localparam logic [CTRLW-1:0] C_LW   = 12'h00F;
  localparam logic [CTRLW-1:0] C_ADD  = 12'h404;
  localparam logic [CTRLW-1:0] C_ADDI = 12'h405;
  localparam logic [CTRLW-1:0] C_BEQ  = 12'hA00;
  localparam logic [CTRLW-1:0] C_JAL  = 12'h044;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             id_valid;
  logic [CTRLW-1:0] id_ctrl;
  logic [REGW-1:0]  id_rs1, id_rs2, id_rd;
  logic             ex_take;
  logic [CTRLW-1:0] ex_ctrl, mem_ctrl, wb_ctrl;
  logic [REGW-1:0]  ex_rd, mem_rd, wb_rd, ex_rs1, ex_rs2;
  logic             ex_valid, mem_valid, wb_valid, stall_if, flush_ifid;
  logic [1:0]       fwd_a, fwd_b;

  int n_chk = 0;
  int n_err = 0;

  ctrl_pipe #(.REGW(REGW), .CTRLW(CTRLW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .ex_take(ex_take),
    .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
    .stall_if(stall_if), .flush_ifid(flush_ifid),
    .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [CTRLW-1:0] c,
                       input int rs1, input int rs2, input int rd, input logic take);
    id_valid = v;
    id_ctrl  = c;
    id_rs1   = REGW'(rs1);
    id_rs2   = REGW'(rs2);
    id_rd    = REGW'(rd);
    ex_take  = take;
    #1;  // let combinational outputs settle
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    drive(1'b0, '0, 0, 0, 0, 1'b0);
    repeat (3) tick();
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, '0, 0, 0, 0, 1'b0);
    repeat (2) tick();

    // Reset state
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_ex_ctrl",  ex_ctrl, 0);
    chk("rst_wb_ctrl",  wb_ctrl, 0);
    chk("rst_stall",    stall_if, 0);
    chk("rst_flush",    flush_ifid, 0);
    chk("rst_fwd_a",    fwd_a, 0);

    // Mid-stream reset drops in-flight RegWrite instructions
    rst_n = 1'b1;
    drive(1'b1, C_ADD, 1, 2, 6, 1'b0);
    tick();
    drive(1'b1, C_ADD, 3, 4, 7, 1'b0);
    tick();
    chk("pipe_mem_valid", mem_valid, 1);
    chk("pipe_mem_rd",    mem_rd, 6);
    chk("pipe_ex_rd",     ex_rd, 7);
    drive(1'b0, '0, 0, 0, 0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_ex_valid",  ex_valid, 0);
    chk("mrst_mem_valid", mem_valid, 0);
    chk("mrst_mem_ctrl",  mem_ctrl, 0);
    chk("mrst_ex_ctrl",   ex_ctrl, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1'b1, C_ADD, 1, 2, 8, 1'b0);
    tick();
    drive(1'b0, '0, 0, 0, 0, 1'b0);
    tick();
    chk("lat2_wb_valid",  wb_valid, 0);
    chk("lat2_mem_valid", mem_valid, 1);
    tick();
    chk("lat3_wb_valid",  wb_valid, 1);
    chk("lat3_wb_rd",     wb_rd, 8);
    chk("lat3_wb_ctrl",   wb_ctrl, C_ADD);
    drain();

    // Load-use: lw x5 in EX, add x6,x5,x1 in ID
    drive(1'b1, C_LW, 1, 0, 5, 1'b0);
    tick();
    drive(1'b1, C_ADD, 5, 1, 6, 1'b0);
    chk("lu_stall", stall_if, 1);
    chk("lu_flush", flush_ifid, 0);
    tick();
    chk("lu_ex_bubble", ex_valid, 0);
    chk("lu_ex_ctrl0",  ex_ctrl, 0);
    chk("lu_mem_rd",    mem_rd, 5);
`ifdef CTRL_PIPE_FWD_EN
    chk("lu_stall_once", stall_if, 0);
    tick();
`else
    chk("lu_stall_mem", stall_if, 1);
    tick();
    chk("lu_ex_bubble2", ex_valid, 0);
    chk("lu_stall_done", stall_if, 0);
    tick();
`endif
    chk("lu_ex_valid", ex_valid, 1);
    chk("lu_ex_rd",    ex_rd, 6);
`ifdef CTRL_PIPE_FWD_EN
    chk("lu_fwd_a", fwd_a, 2'b01);
`else
    chk("lu_fwd_a", fwd_a, 2'b00);
`endif
    chk("lu_fwd_b", fwd_b, 2'b00);
    drain();

    // x0 immunity
    drive(1'b1, C_LW, 1, 0, 0, 1'b0);
    tick();
    drive(1'b1, C_ADD, 0, 0, 6, 1'b0);
    chk("x0_stall", stall_if, 0);
    tick();
    drive(1'b0, '0, 0, 0, 0, 1'b0);
    chk("x0_ex_valid", ex_valid, 1);
    chk("x0_fwd_a", fwd_a, 0);
    chk("x0_fwd_b", fwd_b, 0);
    drain();

    // Taken branch flush
    drive(1'b1, C_BEQ, 1, 2, 0, 1'b0);
    tick();
    drive(1'b1, C_ADD, 3, 4, 9, 1'b1);
    chk("br_flush", flush_ifid, 1);
    chk("br_stall", stall_if, 0);
    tick();
    drive(1'b0, '0, 0, 0, 0, 1'b0);
    chk("br_ex_bubble", ex_valid, 0);
    chk("br_mem_valid", mem_valid, 1);
    chk("br_mem_ctrl",  mem_ctrl, C_BEQ);
    drain();

    // jal link write survives its own flush
    drive(1'b1, C_JAL, 0, 0, 1, 1'b0);
    tick();
    drive(1'b1, C_ADD, 3, 4, 9, 1'b1);
    chk("jal_flush", flush_ifid, 1);
    tick();
    drive(1'b0, '0, 0, 0, 0, 1'b0);
    chk("jal_ex_bubble", ex_valid, 0);
    tick();
    chk("jal_wb_valid", wb_valid, 1);
    chk("jal_wb_rd",    wb_rd, 1);
    chk("jal_wb_rw",    wb_ctrl[2], 1);
    drain();

    // Flush beats load-use
    drive(1'b1, C_LW, 1, 0, 5, 1'b0);
    tick();
    drive(1'b1, C_ADD, 5, 1, 6, 1'b1);
    chk("fl_lu_flush", flush_ifid, 1);
    chk("fl_lu_stall", stall_if, 0);
    tick();
    drive(1'b0, '0, 0, 0, 0, 1'b0);
    chk("fl_lu_bubble", ex_valid, 0);
    drain();

    // MEM vs WB producers of x3; EX reads x3 on both operands
    drive(1'b1, C_ADDI, 1, 0, 3, 1'b0);
    tick();
    drive(1'b1, C_ADD, 1, 2, 3, 1'b0);
    tick();
    drive(1'b1, C_ADD, 3, 3, 10, 1'b0);
`ifdef CTRL_PIPE_FWD_EN
    chk("fp_stall", stall_if, 0);
    tick();
    chk("fp_fwd_a", fwd_a, 2'b10);
    chk("fp_fwd_b", fwd_b, 2'b10);
`else
    chk("fp_stall_ex", stall_if, 1);
    tick();
    chk("fp_stall_mem", stall_if, 1);
    chk("fp_bubble", ex_valid, 0);
    tick();
    chk("fp_stall_clr", stall_if, 0);
    tick();
    chk("fp_fwd_a", fwd_a, 2'b00);
    chk("fp_fwd_b", fwd_b, 2'b00);
`endif
    chk("fp_ex_rd", ex_rd, 10);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
